serial_tx: RTL and testbench
============================

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1: clock cycles each serial bit is held (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset; sampled only on the rising edge of clk.
REQ-004 SHALL have port valid  input  1  frame request; qualifies data.
REQ-005 SHALL have port data  input  8  byte to transmit.
REQ-006 SHALL have port ready  output  1  high when a request is accepted this cycle.
REQ-007 SHALL have port tx  output  1  serial line, idle high.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking the end of a frame.

Function
REQ-009 SHALL be a Moore FSM with states IDLE, START, DATA, PARITY, STOP; tx, ready and done depend on state and counters only.
REQ-010 SHALL assert ready only in IDLE; a frame is accepted on a rising edge where valid && ready.
REQ-011 SHALL latch data into an internal shift register on acceptance; later changes to data SHALL NOT affect the frame in flight.
REQ-012 SHALL drive tx=0 (start bit) from the cycle after acceptance: IDLE->START.
REQ-013 SHALL send data LSB first in DATA state, 8 bits, with a 3-bit bit index that moves to the next state after bit 7.
REQ-014 SHALL hold every bit (start, data, parity, stop) for exactly CLKS_PER_BIT cycles, using a down-counter of $clog2(CLKS_PER_BIT+1) bits reloaded on each bit boundary.
REQ-015 SHALL drive tx=1 in STOP, then return to IDLE; minimum one IDLE cycle between frames (no back-to-back acceptance).
REQ-016 SHALL pulse done=1 for exactly the last clock cycle of STOP; done=0 otherwise.
REQ-017 SHALL drive tx=1 in IDLE, ignoring valid while not in IDLE (no queueing, request not acknowledged).
REQ-018 SHALL treat an unreachable state encoding as IDLE on the next edge with tx=1.

Reset
REQ-019 SHALL, on reset=1 at a rising edge, enter IDLE with tx=1, ready=1, done=0, counters and shift register cleared.
REQ-020 SHALL abort an in-flight frame on reset mid-operation; no done pulse for the aborted frame; tx=1 from the next cycle.
REQ-021 SHALL give reset priority over valid in the same cycle: the request is not accepted.

Configuration
REQ-022 SHALL, with macro SERIAL_TX_PARITY_EN defined, insert state PARITY between DATA and STOP, sending odd parity (tx = ~^data_latched) for CLKS_PER_BIT cycles; frame = 11 bits.
REQ-023 SHALL, without SERIAL_TX_PARITY_EN, go DATA->STOP directly; PARITY state absent; frame = 10 bits.

Structure
REQ-024 SHALL place the state typedef/encoding (IDLE..STOP) and constants DATA_BITS=8, FRAME_BITS_PAR=11, FRAME_BITS_NOPAR=10 in shared package serial_pkg.
REQ-025 SHALL keep the bit-period counter in sub-module serial_bit_timer (inputs load, period; output tick); all other logic stays in serial_tx.

Verification
REQ-026 SHALL check CLKS_PER_BIT=1, parity on, data=8'hA5 accepted at cycle 0 -> tx cycles 1..11 = 0,1,0,1,0,0,1,0,1,1,1; done=1 at cycle 11; ready=1 again at cycle 12.
REQ-027 SHALL check CLKS_PER_BIT=4, parity off, data=8'h00 -> tx low for 36 cycles (start + 8 data), then high for 4; done on the 40th cycle after acceptance.
REQ-028 SHALL check data changed to 8'hFF one cycle after accepting 8'h0F -> serialized bits remain 1,1,1,1,0,0,0,0.
REQ-029 SHALL check valid held high through a frame -> exactly one acceptance per frame, with ready=0 from START to end of STOP.
REQ-030 SHALL check reset asserted during data bit 3 -> next cycle tx=1, ready=1, done never pulses; a new frame of 8'h3C then transmits correctly.
REQ-031 SHALL check parity on, data=8'h07 (3 ones) -> parity bit 0; data=8'h03 -> parity bit 1.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and frame constants for serial_tx.
package serial_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int DATA_BITS = 8;
    localparam int FRAME_BITS_PAR = 11;
    localparam int FRAME_BITS_NOPAR = 10;
endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer: bit-period down-counter; tick marks the last cycle of a bit.
module serial_bit_timer #(parameter int W = 1) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] period,
    output logic         tick
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= period - W'(1);
        else if (cnt != '0) cnt <= cnt - W'(1);
    end
    assign tick = cnt == '0;
endmodule

// File: rtl/serial_tx.sv
// serial_tx: 8N1 serial transmitter (start, 8 data LSB first, stop).
// Define SERIAL_TX_PARITY_EN to insert an odd-parity bit before the stop bit.
module serial_tx import serial_pkg::*; #(parameter int CLKS_PER_BIT = 1) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx,
    output logic       done
);
    localparam int W = $clog2(CLKS_PER_BIT + 1);
    state_t state;
    logic [7:0] sreg;
    logic [2:0] idx;
    logic tick;
`ifdef SERIAL_TX_PARITY_EN
    logic par;
`endif
    // The timer is held loaded while idle so START gets a full bit period.
    serial_bit_timer #(.W(W)) u_timer (
        .clk(clk),
        .reset(reset),
        .load(state == IDLE || tick),
        .period(W'(CLKS_PER_BIT)),
        .tick(tick)
    );
    assign done = state == STOP && tick;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tx <= 1'b1;
            ready <= 1'b1;
            sreg <= '0;
            idx <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (valid && ready) begin
                    state <= START;
                    sreg <= data;
`ifdef SERIAL_TX_PARITY_EN
                    par <= ~^data;
`endif
                    idx <= '0;
                    tx <= 1'b0;
                    ready <= 1'b0;
                end
                START: if (tick) begin
                    state <= DATA;
                    tx <= sreg[0];
                end
                DATA: if (tick) begin
                    if (idx == 3'(DATA_BITS - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
                        state <= PARITY;
                        tx <= par;
`else
                        state <= STOP;
                        tx <= 1'b1;
`endif
                    end else begin
                        idx <= idx + 3'd1;
                        sreg <= sreg >> 1;
                        tx <= sreg[1];
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: if (tick) begin
                    state <= STOP;
                    tx <= 1'b1;
                end
`endif
                STOP: if (tick) begin
                    state <= IDLE;
                    ready <= 1'b1;
                    tx <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    tx <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: scoreboard bench for serial_tx, one instance at 1 and one at 4 clocks per bit.
module tb_serial_tx;
    import serial_pkg::*;
    typedef struct packed {logic [7:0] d; logic par;} exp_t;
    logic clk = 1'b0;
    logic reset;
    logic valid_v [2];
    logic [7:0] data_v [2];
    logic ready_v [2];
    logic tx_v [2];
    logic done_v [2];
    int acc [2];
    logic act_m [2];
    exp_t q0 [$];
    exp_t q1 [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_tx #(.CLKS_PER_BIT(1)) u0 (
        .clk(clk), .reset(reset), .valid(valid_v[0]), .data(data_v[0]),
        .ready(ready_v[0]), .tx(tx_v[0]), .done(done_v[0])
    );
    serial_tx #(.CLKS_PER_BIT(4)) u1 (
        .clk(clk), .reset(reset), .valid(valid_v[1]), .data(data_v[1]),
        .ready(ready_v[1]), .tx(tx_v[1]), .done(done_v[1])
    );

    task automatic chk(input int i, input string nm, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL inst%0d %s: got %b expected %b at %0t", i, nm, a, e, $time);
        end
    endtask

    // Frame model: expected tx per cycle is bit k/p of {stop, [parity,] data, start}.
    task automatic monitor(input int i);
        int p, nb, k;
        logic act, idle;
        logic [10:0] fr;
        exp_t e;
        p = (i == 0) ? 1 : 4;
`ifdef SERIAL_TX_PARITY_EN
        nb = FRAME_BITS_PAR;
`else
        nb = FRAME_BITS_NOPAR;
`endif
        act = 1'b0;
        k = 0;
        fr = '1;
        forever begin
            @(negedge clk);
            idle = !act;
            if (act) begin
                chk(i, "tx", tx_v[i], fr[k / p]);
                chk(i, "ready_busy", ready_v[i], 1'b0);
                chk(i, "done", done_v[i], k == nb * p - 1);
                k++;
                if (k == nb * p) act = 1'b0;
            end else begin
                chk(i, "tx_idle", tx_v[i], 1'b1);
                chk(i, "ready_idle", ready_v[i], 1'b1);
                chk(i, "done_idle", done_v[i], 1'b0);
            end
            if (reset) act = 1'b0;
            else if (idle && valid_v[i]) begin
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL inst%0d accept: got unexpected request expected none queued", i);
                end else begin
                    if (i == 0) e = q0.pop_front();
                    else e = q1.pop_front();
`ifdef SERIAL_TX_PARITY_EN
                    fr = {1'b1, e.par, e.d, 1'b0};
`else
                    fr = {2'b11, e.d, 1'b0};
`endif
                    act = 1'b1;
                    k = 0;
                    acc[i]++;
                end
            end
            act_m[i] = act;
        end
    endtask

    task automatic send(input int i, input logic [7:0] d, input logic par, input logic keep);
        int tgt;
        exp_t e;
        e.d = d;
        e.par = par;
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
        data_v[i] = d;
        valid_v[i] = 1'b1;
        tgt = acc[i] + 1;
        for (int n = 0; n < 300 && acc[i] != tgt; n++) @(posedge clk);
        if (acc[i] != tgt) begin
            checks++;
            errors++;
            $display("FAIL inst%0d accept_timeout: got %0d accepts expected %0d", i, acc[i], tgt);
        end
        #1;
        if (!keep) valid_v[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            if (!act_m[i]) break;
        end
        if (act_m[i]) begin
            checks++;
            errors++;
            $display("FAIL inst%0d idle_timeout: got busy expected idle", i);
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        valid_v = '{1'b0, 1'b0};
        data_v = '{8'h00, 8'h00};
        acc = '{0, 0};
        act_m = '{1'b0, 1'b0};
        @(posedge clk);
        fork
            monitor(0);
            monitor(1);
        join_none
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(0, 8'hA5, 1'b1, 1'b0);
        wait_idle(0);
        send(1, 8'h00, 1'b1, 1'b0);
        wait_idle(1);
        // In-flight frame must ignore a data change one cycle after acceptance.
        send(0, 8'h0F, 1'b1, 1'b0);
        data_v[0] = 8'hFF;
        wait_idle(0);
        send(0, 8'h55, 1'b1, 1'b1);
        send(0, 8'h81, 1'b1, 1'b0);
        wait_idle(0);
        // Abort during data bit 3 (cycle 5 after acceptance at 1 clock per bit).
        send(0, 8'hE1, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(0, 8'h3C, 1'b1, 1'b0);
        wait_idle(0);
        valid_v[0] = 1'b1;
        data_v[0] = 8'hAA;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        valid_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send(0, 8'h07, 1'b0, 1'b0);
        wait_idle(0);
        send(0, 8'h03, 1'b1, 1'b0);
        wait_idle(0);
        send(1, 8'h3C, 1'b1, 1'b0);
        wait_idle(1);
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
